apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT, default 16: ACCESS-phase cycles allowed without pready before abort.
REQ-002 pclk  in  1  single clock; all logic on rising edge.
REQ-003 preset  in  1  reset; asynchronous, active-high.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at a pclk edge.
REQ-006 cmd_write  in  1  1=write, 0=read.
REQ-007 cmd_addr  in  32  target address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 cmd_strobe  in  2  byte count: 00=1, 01=2, 10=3, 11=4 (low bytes).
REQ-010 rsp_valid  out  1  one-cycle response pulse.
REQ-011 rsp_rdata  out  32  read data, byte-masked; 0 for writes and timeouts.
REQ-012 rsp_timeout  out  1  qualifies rsp_valid; 1 = transfer aborted.
REQ-013 psel, penable, pwrite  out  1 each  APB control.
REQ-014 paddr, pwdata  out  32 each  APB address/data.
REQ-015 p_strobe  out  2  same encoding as cmd_strobe.
REQ-016 prdata  in  32  slave read data.
REQ-017 pready  in  1  slave completion.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS, RESP; encoding from shared package.
REQ-019 cmd_ready SHALL be 1 only in IDLE; command fields registered on acceptance.
REQ-020 Acceptance edge -> SETUP: psel=1, penable=0, pwrite/paddr/p_strobe/pwdata driven from registered command.
REQ-021 SETUP -> ACCESS unconditionally after one cycle: psel=1, penable=1.
REQ-022 ACCESS: psel, penable, paddr, pwrite, pwdata, p_strobe held stable until exit.
REQ-023 ACCESS with pready=1 at an edge -> RESP; prdata captured on that edge for reads.
REQ-024 pwdata: bytes above strobe count forced to 0 (strobe 00 -> only [7:0] non-zero).
REQ-025 rsp_rdata: prdata masked to strobe byte count, upper bytes 0.
REQ-026 RESP: psel=penable=0, rsp_valid=1 for exactly one cycle, then IDLE.
REQ-027 Minimum latency: acceptance edge to rsp_valid high = 3 cycles (SETUP, ACCESS, RESP).
REQ-028 Wait-state counter cleared on ACCESS entry, incremented each ACCESS cycle with pready=0.
REQ-029 Counter reaching TIMEOUT with pready=0 -> RESP with rsp_timeout=1, rsp_rdata=0; psel/penable deasserted.
REQ-030 pready=1 on the same edge the counter reaches TIMEOUT: normal completion wins, rsp_timeout=0.
REQ-031 pready outside ACCESS ignored; cmd_valid outside IDLE ignored (not queued).
REQ-032 Back-to-back: next command accepted in IDLE cycle after RESP; psel low at least one cycle between transfers.
REQ-033 Counter width $clog2(TIMEOUT+1); no wrap beyond TIMEOUT.

Reset
REQ-034 preset asserted: state=IDLE, psel=penable=pwrite=0, paddr=pwdata=0, p_strobe=00, rsp_valid=rsp_timeout=0, rsp_rdata=0, counter=0, cmd_ready=0 while asserted.
REQ-035 Reset mid-transfer aborts without response; cmd_ready=1 the first cycle after deassertion.

Structure
REQ-036 Package apb_pkg: state enum, strobe encodings, strobe-to-byte-mask function.
REQ-037 One sub-module natural: apb_wdog (wait-state counter with clear, enable, expired output).

Verification
REQ-038 Write addr 0x10, data 0xA5A5A5A5, strobe 11, pready after 2 wait cycles -> SETUP 1 cycle, ACCESS 3 cycles, rsp_valid 1 cycle, rsp_timeout=0.
REQ-039 Read strobe 01, prdata=0xDEADBEEF, pready immediate -> rsp_rdata=0x0000BEEF, rsp_valid 3 cycles after acceptance.
REQ-040 Write strobe 00, cmd_wdata=0x12345678 -> pwdata=0x00000078 throughout SETUP/ACCESS.
REQ-041 TIMEOUT=16, pready never -> after 16 ACCESS cycles rsp_valid=1, rsp_timeout=1, rsp_rdata=0, psel=0.
REQ-042 preset pulsed during ACCESS -> psel/penable 0 immediately (async), no rsp_valid, cmd_ready=1 next cycle after release.
REQ-043 cmd_valid held high for two commands -> second accepted in IDLE after first RESP, psel low one cycle between.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg -- shared definitions for the APB master.
//   apb_state_e : FSM state encoding (IDLE, SETUP, ACCESS, RESP)
//   STRB_*      : cmd_strobe / p_strobe byte-count encodings
//   strb_mask() : strobe encoding -> 32-bit byte-lane mask (low bytes kept)
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [1:0] STRB_1B = 2'b00;
  localparam logic [1:0] STRB_2B = 2'b01;
  localparam logic [1:0] STRB_3B = 2'b10;
  localparam logic [1:0] STRB_4B = 2'b11;

  // Strobe is a byte count, not a lane enable: bytes above the count are zero.
  function automatic logic [31:0] strb_mask(input logic [1:0] strobe);
    logic [31:0] mask;
    case (strobe)
      STRB_1B: mask = 32'h0000_00FF;
      STRB_2B: mask = 32'h0000_FFFF;
      STRB_3B: mask = 32'h00FF_FFFF;
      STRB_4B: mask = 32'hFFFF_FFFF;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if -- groups the command/response side and the APB bus side of
// the APB master.
//   cmd_*  : command request (valid/ready handshake, write, addr, wdata, strobe)
//   rsp_*  : one-cycle response pulse with read data and timeout flag
//   p*     : APB bus (psel, penable, pwrite, paddr, pwdata, p_strobe, prdata, pready)
// Modports: master (the apb_master block), slave (its environment).
interface apb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [1:0]  cmd_strobe;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [1:0]  p_strobe;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strobe, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata, p_strobe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strobe, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata, p_strobe
  );
endinterface

// File: rtl/apb_wdog.sv
// apb_wdog -- ACCESS-phase wait-state counter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : clear counter to 0 (has priority over en_i)
//   en_i         : count one wait state this cycle
//   expired_o    : this cycle's increment makes the counter reach TIMEOUT
// The counter saturates at TIMEOUT and never wraps.
module apb_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next counter value: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flagged one cycle early so the FSM leaves ACCESS on the very edge where
  // the count reaches TIMEOUT.
  assign expired_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// apb_master -- single-outstanding APB master.
//   pclk   : clock, rising edge
//   preset : asynchronous active-high reset
//   bus    : apb_master_if.master -- command/response handshake and APB bus
// A command accepted in IDLE runs SETUP (1 cycle), ACCESS (until pready or
// TIMEOUT wait states), then RESP (one-cycle rsp_valid) and returns to IDLE.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic          pclk,
  input logic          preset,
  apb_master_if.master bus
);

  apb_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  strobe_q, strobe_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        wdog_clr;
  logic        wdog_en;
  logic        wdog_expired;

  // SETUP always precedes ACCESS, so clearing there gives a fresh count on entry.
  assign wdog_clr = (state_q == ST_SETUP);
  assign wdog_en  = (state_q == ST_ACCESS) && !bus.pready;

  apb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i     (pclk),
    .rst_i     (preset),
    .clr_i     (wdog_clr),
    .en_i      (wdog_en),
    .expired_o (wdog_expired)
  );

  // Next-state, command capture and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strobe_d      = strobe_q;
    rsp_rdata_d   = 32'h0000_0000;
    rsp_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d  = ST_SETUP;
          write_d  = bus.cmd_write;
          addr_d   = bus.cmd_addr;
          wdata_d  = bus.cmd_wdata & strb_mask(bus.cmd_strobe);
          strobe_d = bus.cmd_strobe;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready is tested first so a completion on the expiry edge wins.
        if (bus.pready) begin
          state_d = ST_RESP;
          if (!write_q) begin
            rsp_rdata_d = bus.prdata & strb_mask(strobe_q);
          end else begin
            rsp_rdata_d = 32'h0000_0000;
          end
        end else if (wdog_expired) begin
          state_d       = ST_RESP;
          rsp_timeout_d = 1'b1;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State, captured command and registered output flops.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= 32'h0000_0000;
      wdata_q       <= 32'h0000_0000;
      strobe_q      <= 2'b00;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      strobe_q      <= strobe_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  // Gated by preset so no command can be taken while reset is held.
  assign bus.cmd_ready   = (state_q == ST_IDLE) && !preset;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = write_q;
  assign bus.paddr       = addr_q;
  assign bus.pwdata      = wdata_q;
  assign bus.p_strobe    = strobe_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  logic pclk;
  logic preset;
  int   n_cmp;
  int   n_err;

  apb_master_if bus_if ();

  apb_master #(.TIMEOUT(16)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus_if)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    preset = 1'b1;
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_write  = 1'b0;
    bus_if.cmd_addr   = 32'h0;
    bus_if.cmd_wdata  = 32'h0;
    bus_if.cmd_strobe = 2'b00;
    bus_if.prdata     = 32'h0;
    bus_if.pready     = 1'b0;

    // Reset state
    step(); step();
    chk("rst_psel",      {31'h0, bus_if.psel},      32'h0);
    chk("rst_penable",   {31'h0, bus_if.penable},   32'h0);
    chk("rst_cmd_ready", {31'h0, bus_if.cmd_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
    chk("rst_paddr",     bus_if.paddr,              32'h0);
    chk("rst_pwdata",    bus_if.pwdata,             32'h0);
    chk("rst_rdata",     bus_if.rsp_rdata,          32'h0);
    preset = 1'b0;
    #1;
    chk("rel_cmd_ready", {31'h0, bus_if.cmd_ready}, 32'h1);

    // Write 0x10, strobe 11, pready after two wait states
    step();
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1; bus_if.cmd_addr = 32'h10;
    bus_if.cmd_wdata = 32'hA5A5A5A5; bus_if.cmd_strobe = 2'b11;
    step();  // SETUP
    chk("w1_setup_psel",    {31'h0, bus_if.psel},      32'h1);
    chk("w1_setup_penable", {31'h0, bus_if.penable},   32'h0);
    chk("w1_setup_pwrite",  {31'h0, bus_if.pwrite},    32'h1);
    chk("w1_setup_paddr",   bus_if.paddr,              32'h10);
    chk("w1_setup_pwdata",  bus_if.pwdata,             32'hA5A5A5A5);
    chk("w1_setup_strobe",  {30'h0, bus_if.p_strobe},  32'h3);
    chk("w1_setup_ready",   {31'h0, bus_if.cmd_ready}, 32'h0);
    bus_if.cmd_valid = 1'b0;
    step();  // ACCESS 1
    chk("w1_acc1_penable", {31'h0, bus_if.penable}, 32'h1);
    chk("w1_acc1_psel",    {31'h0, bus_if.psel},    32'h1);
    step();  // ACCESS 2
    chk("w1_acc2_penable", {31'h0, bus_if.penable},   32'h1);
    chk("w1_acc2_rsp",     {31'h0, bus_if.rsp_valid}, 32'h0);
    step();  // ACCESS 3
    chk("w1_acc3_penable", {31'h0, bus_if.penable}, 32'h1);
    chk("w1_acc3_paddr",   bus_if.paddr,            32'h10);
    bus_if.pready = 1'b1;
    step();  // RESP
    chk("w1_rsp_valid",   {31'h0, bus_if.rsp_valid},   32'h1);
    chk("w1_rsp_timeout", {31'h0, bus_if.rsp_timeout}, 32'h0);
    chk("w1_rsp_rdata",   bus_if.rsp_rdata,            32'h0);
    chk("w1_rsp_psel",    {31'h0, bus_if.psel},        32'h0);
    bus_if.pready = 1'b0;
    step();  // IDLE
    chk("w1_idle_rsp",   {31'h0, bus_if.rsp_valid}, 32'h0);
    chk("w1_idle_ready", {31'h0, bus_if.cmd_ready}, 32'h1);

    // Read strobe 01, pready immediate (pready high early must be ignored)
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b0; bus_if.cmd_addr = 32'h20;
    bus_if.cmd_strobe = 2'b01; bus_if.prdata = 32'hDEADBEEF; bus_if.pready = 1'b1;
    step();  // SETUP
    chk("r1_setup_psel",    {31'h0, bus_if.psel},    32'h1);
    chk("r1_setup_penable", {31'h0, bus_if.penable}, 32'h0);
    chk("r1_setup_pwrite",  {31'h0, bus_if.pwrite},  32'h0);
    bus_if.cmd_valid = 1'b0;
    step();  // ACCESS
    chk("r1_acc_penable", {31'h0, bus_if.penable},   32'h1);
    chk("r1_acc_rsp",     {31'h0, bus_if.rsp_valid}, 32'h0);
    step();  // RESP, third cycle after acceptance
    chk("r1_rsp_valid",   {31'h0, bus_if.rsp_valid},   32'h1);
    chk("r1_rsp_rdata",   bus_if.rsp_rdata,            32'h0000BEEF);
    chk("r1_rsp_timeout", {31'h0, bus_if.rsp_timeout}, 32'h0);
    bus_if.pready = 1'b0;
    step();  // IDLE
    chk("r1_idle_rsp",   {31'h0, bus_if.rsp_valid}, 32'h0);
    chk("r1_idle_rdata", bus_if.rsp_rdata,          32'h0);

    // Write strobe 00: only low byte on pwdata
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1; bus_if.cmd_addr = 32'h30;
    bus_if.cmd_wdata = 32'h12345678; bus_if.cmd_strobe = 2'b00;
    step();  // SETUP
    chk("w0_setup_pwdata", bus_if.pwdata,             32'h00000078);
    chk("w0_setup_strobe", {30'h0, bus_if.p_strobe},  32'h0);
    bus_if.cmd_valid = 1'b0;
    step();  // ACCESS
    chk("w0_acc_pwdata", bus_if.pwdata, 32'h00000078);
    bus_if.pready = 1'b1;
    step();  // RESP
    chk("w0_rsp_valid", {31'h0, bus_if.rsp_valid}, 32'h1);
    bus_if.pready = 1'b0;
    step();  // IDLE

    // Timeout: pready never arrives
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b0; bus_if.cmd_addr = 32'h50;
    bus_if.cmd_strobe = 2'b11; bus_if.prdata = 32'h11223344;
    step();  // SETUP
    bus_if.cmd_valid = 1'b0;
    step();  // ACCESS 1
    chk("to_acc1_penable", {31'h0, bus_if.penable}, 32'h1);
    for (int i = 0; i < 15; i++) begin  // ACCESS 2..16
      step();
      chk("to_acc_penable", {31'h0, bus_if.penable},   32'h1);
      chk("to_acc_rsp",     {31'h0, bus_if.rsp_valid}, 32'h0);
    end
    step();  // RESP after 16 ACCESS cycles
    chk("to_rsp_valid",   {31'h0, bus_if.rsp_valid},   32'h1);
    chk("to_rsp_timeout", {31'h0, bus_if.rsp_timeout}, 32'h1);
    chk("to_rsp_rdata",   bus_if.rsp_rdata,            32'h0);
    chk("to_rsp_psel",    {31'h0, bus_if.psel},        32'h0);
    chk("to_rsp_penable", {31'h0, bus_if.penable},     32'h0);
    step();  // IDLE
    chk("to_idle_timeout", {31'h0, bus_if.rsp_timeout}, 32'h0);

    // pready on the expiry edge: normal completion wins
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b0; bus_if.cmd_addr = 32'h60;
    bus_if.cmd_strobe = 2'b10; bus_if.prdata = 32'hCAFEF00D;
    step();  // SETUP
    bus_if.cmd_valid = 1'b0;
    step();  // ACCESS 1
    for (int i = 0; i < 15; i++) begin
      step();
    end
    chk("race_acc16_penable", {31'h0, bus_if.penable}, 32'h1);
    bus_if.pready = 1'b1;
    step();  // RESP
    chk("race_rsp_valid",   {31'h0, bus_if.rsp_valid},   32'h1);
    chk("race_rsp_timeout", {31'h0, bus_if.rsp_timeout}, 32'h0);
    chk("race_rsp_rdata",   bus_if.rsp_rdata,            32'h00FEF00D);
    bus_if.pready = 1'b0;
    step();  // IDLE

    // Reset pulsed during ACCESS
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1; bus_if.cmd_addr = 32'h70;
    bus_if.cmd_wdata = 32'h55AA55AA; bus_if.cmd_strobe = 2'b11;
    step();  // SETUP
    bus_if.cmd_valid = 1'b0;
    step();  // ACCESS
    chk("rp_acc_penable", {31'h0, bus_if.penable}, 32'h1);
    #2 preset = 1'b1;
    #1;
    chk("rp_async_psel",    {31'h0, bus_if.psel},      32'h0);
    chk("rp_async_penable", {31'h0, bus_if.penable},   32'h0);
    chk("rp_async_ready",   {31'h0, bus_if.cmd_ready}, 32'h0);
    step();
    chk("rp_held_rsp", {31'h0, bus_if.rsp_valid}, 32'h0);
    preset = 1'b0;
    #1;
    chk("rp_rel_ready", {31'h0, bus_if.cmd_ready}, 32'h1);
    step();
    chk("rp_after_rsp",  {31'h0, bus_if.rsp_valid}, 32'h0);
    chk("rp_after_psel", {31'h0, bus_if.psel},      32'h0);

    // Back-to-back with cmd_valid held high
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1; bus_if.cmd_addr = 32'h40;
    bus_if.cmd_wdata = 32'hFFFFFFFF; bus_if.cmd_strobe = 2'b11; bus_if.pready = 1'b1;
    step();  // SETUP #1
    chk("b2b_s1_paddr", bus_if.paddr, 32'h40);
    bus_if.cmd_addr = 32'h44;
    step();  // ACCESS #1
    chk("b2b_a1_paddr", bus_if.paddr, 32'h40);
    step();  // RESP #1
    chk("b2b_r1_valid", {31'h0, bus_if.rsp_valid}, 32'h1);
    chk("b2b_r1_ready", {31'h0, bus_if.cmd_ready}, 32'h0);
    step();  // IDLE gap, second command accepted here
    chk("b2b_gap_psel",  {31'h0, bus_if.psel},      32'h0);
    chk("b2b_gap_ready", {31'h0, bus_if.cmd_ready}, 32'h1);
    step();  // SETUP #2
    chk("b2b_s2_psel",  {31'h0, bus_if.psel}, 32'h1);
    chk("b2b_s2_paddr", bus_if.paddr,         32'h44);
    bus_if.cmd_valid = 1'b0;
    step();  // ACCESS #2
    step();  // RESP #2
    chk("b2b_r2_valid", {31'h0, bus_if.rsp_valid}, 32'h1);
    bus_if.pready = 1'b0;
    step();  // IDLE
    chk("b2b_end_ready", {31'h0, bus_if.cmd_ready}, 32'h1);
    chk("b2b_end_psel",  {31'h0, bus_if.psel},      32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
